// File: rtl/uart_tx_serializer_if.sv
// Parallel-side request bus and serial-side status of the UART transmit stage.
// Build option UART_TX_TWO_STOP_EN adds the stop_bits request field.
interface uart_tx_serializer_if #(
   parameter int dataWidth = 8
);
   logic [dataWidth-1:0] p_data;
   logic                 data_valid;
   logic                 par_en;
   logic                 par_type;
   logic [5:0]           prescale;
`ifdef UART_TX_TWO_STOP_EN
   logic                 stop_bits;
`endif
   logic                 tx_out;
   logic                 busy;

`ifdef UART_TX_TWO_STOP_EN
   modport master (output p_data, data_valid, par_en, par_type, prescale, stop_bits,
                   input  tx_out, busy);
   modport slave  (input  p_data, data_valid, par_en, par_type, prescale, stop_bits,
                   output tx_out, busy);
`else
   modport master (output p_data, data_valid, par_en, par_type, prescale,
                   input  tx_out, busy);
   modport slave  (input  p_data, data_valid, par_en, par_type, prescale,
                   output tx_out, busy);
`endif
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, dataWidth payload bits LSB first, optional parity, stop bit(s).
// Build option UART_TX_TWO_STOP_EN: bus.stop_bits=1 latched on accept gives two stop bits.
//
// state  | meaning
// IDLE   | line high, busy low, waiting for data_valid
// START  | start bit, line low
// DATA   | payload bit bit_idx, LSB first
// PARITY | parity bit computed from the latched payload
// STOP   | stop bit(s), line high
module uart_tx_serializer #(
   parameter int dataWidth = 8
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_serializer_if.slave bus
);
   localparam int BW = (dataWidth > 2) ? $clog2(dataWidth) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_nxt;
   logic [5:0]           tick, tick_nxt;
   logic [5:0]           ps_lat, ps_lat_nxt;
   logic [BW-1:0]        bit_idx, bit_idx_nxt;
   logic [dataWidth-1:0] shreg, shreg_nxt;
   logic                 par_en_lat, par_en_lat_nxt;
   logic                 par_bit, par_bit_nxt;
   logic                 tx_q, tx_nxt;
   logic                 busy_q, busy_nxt;
   logic                 last_tick;
`ifdef UART_TX_TWO_STOP_EN
   logic                 two_stop, two_stop_nxt;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tick       <= '0;
         ps_lat     <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         par_en_lat <= 1'b0;
         par_bit    <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         two_stop   <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         tick       <= tick_nxt;
         ps_lat     <= ps_lat_nxt;
         bit_idx    <= bit_idx_nxt;
         shreg      <= shreg_nxt;
         par_en_lat <= par_en_lat_nxt;
         par_bit    <= par_bit_nxt;
         tx_q       <= tx_nxt;
         busy_q     <= busy_nxt;
`ifdef UART_TX_TWO_STOP_EN
         two_stop   <= two_stop_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt      = state;
      tick_nxt       = tick;
      ps_lat_nxt     = ps_lat;
      bit_idx_nxt    = bit_idx;
      shreg_nxt      = shreg;
      par_en_lat_nxt = par_en_lat;
      par_bit_nxt    = par_bit;
`ifdef UART_TX_TWO_STOP_EN
      two_stop_nxt   = two_stop;
`endif
      last_tick      = (tick == ps_lat - 6'd1);

      if (state == IDLE) begin
         if (bus.data_valid) begin
            state_nxt      = START;
            tick_nxt       = '0;
            bit_idx_nxt    = '0;
            shreg_nxt      = bus.p_data;
            ps_lat_nxt     = (bus.prescale < 6'd4) ? 6'd4 : bus.prescale;
            par_en_lat_nxt = bus.par_en;
            par_bit_nxt    = bus.par_type ^ (^bus.p_data);
`ifdef UART_TX_TWO_STOP_EN
            two_stop_nxt   = bus.stop_bits;
`endif
         end
      end else if (!last_tick) begin
         tick_nxt = tick + 6'd1;
      end else begin
         tick_nxt = '0;
         case (state)
            START: begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
            end
            DATA: begin
               if (bit_idx == BW'(dataWidth - 1)) begin
                  state_nxt   = par_en_lat ? PARITY : STOP;
                  bit_idx_nxt = '0;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
                  shreg_nxt   = shreg >> 1;
               end
            end
            PARITY: state_nxt = STOP;
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
               // bit_idx doubles as the stop-bit counter once the payload is out
               if (two_stop && bit_idx == '0) bit_idx_nxt = 1'b1;
               else                           state_nxt   = IDLE;
`else
               state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
         endcase
      end

      // outputs are registered, so they are derived from the state being entered
      tx_nxt   = 1'b1;
      busy_nxt = 1'b1;
      case (state_nxt)
         IDLE:    busy_nxt = 1'b0;
         START:   tx_nxt   = 1'b0;
         DATA:    tx_nxt   = shreg_nxt[0];
         PARITY:  tx_nxt   = par_bit_nxt;
         default: tx_nxt   = 1'b1;
      endcase
   end

   assign bus.tx_out = tx_q;
   assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level line model checked every cycle, plus directed frames
// whose bit levels and lengths are pinned to hand-computed values.
module tb_uart_tx_serializer;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_serializer_if #(.dataWidth(DW)) bus ();
   uart_tx_serializer #(.dataWidth(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   vectors     = 0;
   int   miscompares = 0;
   bit   check_en    = 1'b0;
   logic exp_tx      = 1'b1;
   logic exp_busy    = 1'b0;
   logic [1:0] exp_q[$];
   logic cap[$];

   function automatic int eff_ps(logic [5:0] p);
      return (p < 6'd4) ? 4 : int'(p);
   endfunction

   // Expected line: one {tx,busy} entry per clock of the whole frame, built from the frame rules.
   function automatic void build_frame();
      int   p;
      logic b[$];
      p = eff_ps(bus.prescale);
      b.push_back(1'b0);
      for (int i = 0; i < DW; i++) b.push_back(bus.p_data[i]);
      if (bus.par_en) b.push_back(bus.par_type ^ (^bus.p_data));
      b.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
      if (bus.stop_bits) b.push_back(1'b1);
`endif
      foreach (b[i])
         for (int k = 0; k < p; k++) exp_q.push_back({b[i], 1'b1});
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
      end else begin
         if (exp_q.size() == 0 && !exp_busy && bus.data_valid === 1'b1) build_frame();
         if (exp_q.size() > 0) {exp_tx, exp_busy} = exp_q.pop_front();
         else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         vectors++;
         if (bus.tx_out !== exp_tx || bus.busy !== exp_busy) begin
            miscompares++;
            $display("FAIL line @%0t: tx_out=%b busy=%b, expected tx_out=%b busy=%b",
                     $time, bus.tx_out, bus.busy, exp_tx, exp_busy);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && bus.busy !== 1'b0; i++) @(negedge clk);
      check("wait_idle", int'(bus.busy), 0);
   endtask

   task automatic request(input logic [7:0] d, input logic pe, input logic pt,
                          input logic [5:0] ps, input logic sb);
      bus.p_data     = d;
      bus.par_en     = pe;
      bus.par_type   = pt;
      bus.prescale   = ps;
`ifdef UART_TX_TWO_STOP_EN
      bus.stop_bits  = sb;
`else
      if (sb) $display("note: stop_bits request ignored in this build");
`endif
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
   endtask

   // Records tx_out for every busy cycle; optional one-cycle data_valid pulse at cycle pulse_at.
   task automatic capture_frame(output int len, input int pulse_at, input logic [7:0] pulse_data);
      cap.delete();
      len = 0;
      for (int i = 0; i < 4000 && bus.busy === 1'b1; i++) begin
         cap.push_back(bus.tx_out);
         len++;
         if (i == pulse_at) begin
            bus.p_data     = pulse_data;
            bus.data_valid = 1'b1;
         end else if (i == pulse_at + 1) begin
            bus.data_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   function automatic int cap_bit(int k, int p);
      if (k * p + p / 2 >= cap.size()) return -1;
      return int'(cap[k * p + p / 2]);
   endfunction

   function automatic int cap_byte(int p);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = (cap_bit(1 + i, p) == 1);
      return int'(v);
   endfunction

   function automatic logic [5:0] pick_ps();
      case ($urandom_range(0, 4))
         0:       return 6'd8;
         1:       return 6'd16;
         2:       return 6'd32;
         3:       return 6'($urandom_range(0, 7));
         default: return 6'($urandom_range(4, 12));
      endcase
   endfunction

   initial begin
      int   len;
      int   gap;
      logic exp1[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

      bus.p_data     = '0;
      bus.data_valid = 1'b0;
      bus.par_en     = 1'b0;
      bus.par_type   = 1'b0;
      bus.prescale   = 6'd8;
`ifdef UART_TX_TWO_STOP_EN
      bus.stop_bits  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      check("reset_tx", int'(bus.tx_out), 1);
      check("reset_busy", int'(bus.busy), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5, prescale 8, no parity
      request(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
      capture_frame(len, -10, 8'h00);
      check("a5_busy_len", len, 80);
      for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), cap_bit(k, 8), int'(exp1[k]));

      // parity even / odd, prescale 16
      wait_idle();
      request(8'hA5, 1'b1, 1'b0, 6'd16, 1'b0);
      capture_frame(len, -10, 8'h00);
      check("even_busy_len", len, 176);
      check("even_parity", cap_bit(9, 16), 0);
      check("even_stop", cap_bit(10, 16), 1);
      wait_idle();
      request(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0);
      capture_frame(len, -10, 8'h00);
      check("odd_busy_len", len, 176);
      check("odd_parity", cap_bit(9, 16), 1);

      // prescale below 4 is clamped to 4
      wait_idle();
      request(8'h96, 1'b0, 1'b0, 6'd2, 1'b0);
      capture_frame(len, -10, 8'h00);
      check("clamp_busy_len", len, 40);
      check("clamp_byte", cap_byte(4), 8'h96);

      // back-to-back with data_valid held high
      wait_idle();
      bus.p_data     = 8'h00;
      bus.par_en     = 1'b0;
      bus.prescale   = 6'd8;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.p_data = 8'hFF;
      capture_frame(len, -10, 8'h00);
      check("b2b_first_len", len, 80);
      check("b2b_first_byte", cap_byte(8), 8'h00);
      gap = 0;
      while (bus.busy !== 1'b1 && gap < 100) begin
         gap++;
         @(negedge clk);
      end
      bus.data_valid = 1'b0;
      check("b2b_idle_gap", gap, 1);
      capture_frame(len, -10, 8'h00);
      check("b2b_second_byte", cap_byte(8), 8'hFF);

      // reset during data bit 3
      wait_idle();
      request(8'h00, 1'b0, 1'b0, 6'd8, 1'b0);
      repeat (4 * 8 + 3) @(negedge clk);
      check("pre_reset_tx", int'(bus.tx_out), 0);
      #2 rst = 1'b0;
      #1;
      check("midreset_tx", int'(bus.tx_out), 1);
      check("midreset_busy", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      request(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0);
      capture_frame(len, -10, 8'h00);
      check("after_reset_len", len, 80);
      check("after_reset_byte", cap_byte(8), 8'h3C);

      // request while busy is dropped
      wait_idle();
      request(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0);
      capture_frame(len, 20, 8'h11);
      check("drop_len", len, 80);
      check("drop_byte", cap_byte(8), 8'h5A);
      repeat (3) @(negedge clk);
      check("drop_no_second", int'(bus.busy), 0);

      // randomized traffic against the line model
      for (int c = 0; c < 20000; c++) begin
         bus.data_valid = ($urandom_range(0, 3) == 0);
         bus.p_data     = 8'($urandom);
         bus.par_en     = 1'($urandom);
         bus.par_type   = 1'($urandom);
         bus.prescale   = pick_ps();
`ifdef UART_TX_TWO_STOP_EN
         bus.stop_bits  = 1'($urandom);
`endif
         @(negedge clk);
      end
      bus.data_valid = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
